// File: rtl/dmem_responder.sv
// Data-memory responder for the LSU request/response protocol. The array is accessed
// when a request is accepted; the result goes through a fixed-latency pipe into an in-order response FIFO.
module dmem_responder #(
    parameter int MEM_WORDS  = 1024,
    parameter int LAT        = 2,
    parameter int RESP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_we,
    output logic        resp_err
);
    localparam int AW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int PW     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW     = PW + 1;
    localparam int STAGES = LAT - 1;

    typedef struct packed {
        logic [31:0] rdata;
        logic        we;
        logic        err;
    } resp_t;

    logic          fire, push, pop;
    logic          req_err;
    logic [AW-1:0] word_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data, rd_word, ld_data;
    resp_t         ent_in, push_ent, head;

    logic [CW-1:0] outstanding_q, outstanding_d;

    // Outstanding covers pipe + FIFO, so capping it here is what keeps the FIFO from overflowing.
    assign req_ready = !rst && (outstanding_q < CW'(RESP_DEPTH));
    assign fire      = req_valid && req_ready;
    assign word_idx  = req_addr[AW+1:2];

    always_comb begin
        case (req_size)
            2'd0:    req_err = 1'b0;
            2'd1:    req_err = req_addr[0];
            2'd2:    req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if (req_addr[31:2] >= 30'(MEM_WORDS)) req_err = 1'b1;
    end

    // Store data is replicated across lanes so the byte enables alone select the target bytes.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = req_wdata;
        case (req_size)
            2'd0: begin
                wr_be   = 4'b0001 << req_addr[1:0];
                wr_data = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            2'd2:    wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    logic [31:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (fire && req_we && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_word = mem_q[word_idx];
        case (req_size)
            2'd0:    ld_data = {24'd0, rd_word[{req_addr[1:0], 3'b000} +: 8]};
            2'd1:    ld_data = {16'd0, rd_word[{req_addr[1], 4'b0000} +: 16]};
            default: ld_data = rd_word;
        endcase
    end

    always_comb begin
        ent_in.we    = req_we;
        ent_in.err   = req_err;
        ent_in.rdata = (req_we || req_err) ? 32'd0 : ld_data;
    end

    if (STAGES == 0) begin : g_no_pipe
        assign push     = fire;
        assign push_ent = ent_in;
    end else begin : g_pipe
        logic  [STAGES:1] vld_pipe_q, vld_pipe_d;
        resp_t [STAGES:1] ent_pipe_q, ent_pipe_d;

        always_comb begin
            vld_pipe_d    = vld_pipe_q;
            ent_pipe_d    = ent_pipe_q;
            vld_pipe_d[1] = fire;
            ent_pipe_d[1] = ent_in;
            for (int i = 2; i <= STAGES; i++) begin
                vld_pipe_d[i] = vld_pipe_q[i-1];
                ent_pipe_d[i] = ent_pipe_q[i-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_pipe_q <= '0;
                ent_pipe_q <= '0;
            end else begin
                vld_pipe_q <= vld_pipe_d;
                ent_pipe_q <= ent_pipe_d;
            end
        end

        assign push     = vld_pipe_q[STAGES];
        assign push_ent = ent_pipe_q[STAGES];
    end

    resp_t [RESP_DEPTH-1:0] fifo_q, fifo_d;
    logic  [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic  [CW-1:0]         count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign resp_valid = (count_q != '0);
    assign pop        = resp_valid && resp_ready;
    assign head       = fifo_q[rd_ptr_q];
    assign resp_rdata = resp_valid ? head.rdata : 32'd0;
    assign resp_we    = resp_valid && head.we;
    assign resp_err   = resp_valid && head.err;

    always_comb begin
        fifo_d        = fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        if (push) begin
            fifo_d[wr_ptr_q] = push_ent;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        case ({fire, pop})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
        end else begin
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and scoreboarded bench for dmem_responder (MEM_WORDS=1024, LAT=2, RESP_DEPTH=4).
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_we, resp_err;
    logic [31:0] resp_rdata;

    dmem_responder #(.MEM_WORDS(1024), .LAT(2), .RESP_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_we(resp_we), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        we;
        logic        err;
    } exp_t;

    exp_t        expq[$];
    exp_t        pend;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          outst    = 0;
    logic [31:0] smem [0:1023];

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] erd, input logic eerr);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        pend      = '{rd: erd, we: we, err: eerr};
    endtask

    // One clock: check ready against the outstanding count, score any popped response, log a fire.
    task automatic cycle(output bit fired);
        exp_t e;
        #1;
        chk1("req_ready_vs_outstanding", req_ready, (outst < 4));
        if (expq.size() == 0) begin
            chk1("unexpected_resp", resp_valid, 1'b0);
        end else if (resp_valid && resp_ready) begin
            e = expq.pop_front();
            outst--;
            chk32("resp_rdata", resp_rdata, e.rd);
            chk1("resp_we", resp_we, e.we);
            chk1("resp_err", resp_err, e.err);
        end
        fired = req_valid && req_ready;
        if (fired) begin
            expq.push_back(pend);
            outst++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] erd, input logic eerr);
        bit f;
        int n;
        n = 0;
        f = 1'b0;
        drive(we, sz, a, wd, erd, eerr);
        while (!f && n < 50) begin
            cycle(f);
            n++;
        end
        if (!f) chk1("send_accepted", f, 1'b1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        bit f;
        int n;
        n = 0;
        req_valid = 1'b0;
        while (expq.size() != 0 && n < 100) begin
            cycle(f);
            n++;
        end
        chk32("drain_empty", 32'(expq.size()), 32'd0);
    endtask

    function automatic void model(input logic we, input logic [1:0] sz, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic err);
        logic [31:0] w;
        err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
              (a >= 32'h1000);
        rd  = '0;
        if (err) return;
        w = smem[a[11:2]];
        if (we) begin
            case (sz)
                2'd0:    w[8*a[1:0] +: 8] = wd[7:0];
                2'd1:    w[16*a[1] +: 16] = wd[15:0];
                default: w = wd;
            endcase
            smem[a[11:2]] = w;
        end else begin
            case (sz)
                2'd0:    rd = {24'd0, w[8*a[1:0] +: 8]};
                2'd1:    rd = {16'd0, w[16*a[1] +: 16]};
                default: rd = w;
            endcase
        end
    endfunction

    initial begin
        bit          f, have;
        int          acc, n, cyc, r;
        logic        we_r, eerr;
        logic [1:0]  sz_r;
        logic [31:0] a_r, d_r, erd;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        pend = '{rd: 32'd0, we: 1'b0, err: 1'b0};
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_req_ready", req_ready, 1'b0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk32("rst_resp_rdata", resp_rdata, 32'd0);
        chk1("rst_resp_we", resp_we, 1'b0);
        chk1("rst_resp_err", resp_err, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk1("post_rst_req_ready", req_ready, 1'b1);

        // Word store then word load: responses at T+2 and T+3.
        resp_ready = 1'b1;
        drive(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
        cycle(f);
        chk1("t1_store_fire", f, 1'b1);
        drive(1'b0, 2'd2, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
        chk1("t1_no_resp_T1", resp_valid, 1'b0);
        cycle(f);
        chk1("t1_load_fire", f, 1'b1);
        req_valid = 1'b0;
        chk1("t1_store_resp_T2", resp_valid, 1'b1);
        chk1("t1_store_we_T2", resp_we, 1'b1);
        chk1("t1_store_err_T2", resp_err, 1'b0);
        cycle(f);
        chk1("t1_load_resp_T3", resp_valid, 1'b1);
        chk32("t1_load_rdata_T3", resp_rdata, 32'hDEADBEEF);
        drain();

        // Byte store into lane 3, then sub-word readback.
        send(1'b1, 2'd0, 32'h13, 32'h000000AB, 32'd0, 1'b0);
        send(1'b0, 2'd1, 32'h12, 32'd0, 32'h0000ABAD, 1'b0);
        send(1'b0, 2'd0, 32'h13, 32'd0, 32'h000000AB, 1'b0);
        send(1'b0, 2'd1, 32'h10, 32'd0, 32'h0000BEEF, 1'b0);
        send(1'b0, 2'd2, 32'h10, 32'd0, 32'hABADBEEF, 1'b0);
        drain();

        // Error cases; word 0x20 must survive the misaligned store.
        send(1'b1, 2'd2, 32'h20, 32'h12345678, 32'd0, 1'b0);
        send(1'b0, 2'd1, 32'h11, 32'd0, 32'd0, 1'b1);
        send(1'b1, 2'd2, 32'h22, 32'hCAFEF00D, 32'd0, 1'b1);
        send(1'b0, 2'd3, 32'h20, 32'd0, 32'd0, 1'b1);
        send(1'b0, 2'd2, 32'h1000, 32'd0, 32'd0, 1'b1);
        send(1'b1, 2'd0, 32'h1003, 32'h55, 32'd0, 1'b1);
        send(1'b0, 2'd2, 32'h20, 32'd0, 32'h12345678, 1'b0);
        drain();

        // Backpressure: six loads offered, four fit.
        resp_ready = 1'b0;
        acc = 0;
        drive(1'b0, 2'd2, 32'h10, 32'd0, 32'hABADBEEF, 1'b0); cycle(f); acc += int'(f);
        drive(1'b0, 2'd1, 32'h12, 32'd0, 32'h0000ABAD, 1'b0); cycle(f); acc += int'(f);
        drive(1'b0, 2'd0, 32'h21, 32'd0, 32'h00000056, 1'b0); cycle(f); acc += int'(f);
        drive(1'b0, 2'd2, 32'h20, 32'd0, 32'h12345678, 1'b0); cycle(f); acc += int'(f);
        drive(1'b0, 2'd2, 32'h10, 32'd0, 32'hABADBEEF, 1'b0); cycle(f); acc += int'(f);
        drive(1'b0, 2'd2, 32'h20, 32'd0, 32'h12345678, 1'b0); cycle(f); acc += int'(f);
        req_valid = 1'b0;
        chk32("t4_accepted", 32'(acc), 32'd4);
        chk1("t4_req_ready_full", req_ready, 1'b0);
        cycle(f);
        chk32("t4_head_stable0", resp_rdata, 32'hABADBEEF);
        cycle(f);
        chk32("t4_head_stable1", resp_rdata, 32'hABADBEEF);
        chk1("t4_resp_valid_held", resp_valid, 1'b1);
        resp_ready = 1'b1;
        chk1("t4_ready_before_pop", req_ready, 1'b0);
        cycle(f);
        chk1("t4_ready_after_pop", req_ready, 1'b1);
        drain();

        // Seed the random region, then mixed traffic with random backpressure.
        for (int k = 0; k < 16; k++) begin
            a_r = 32'h100 + 32'(k * 4);
            d_r = $urandom;
            model(1'b1, 2'd2, a_r, d_r, erd, eerr);
            send(1'b1, 2'd2, a_r, d_r, erd, eerr);
        end
        drain();
        n = 0; cyc = 0; have = 1'b0;
        while ((n < 200 || expq.size() != 0) && cyc < 20000) begin
            resp_ready = ($urandom_range(0, 3) != 0);
            if (!have) begin
                req_valid = 1'b0;
                if (n < 200 && $urandom_range(0, 4) != 0) begin
                    we_r = 1'($urandom_range(0, 1));
                    sz_r = 2'($urandom_range(0, 3));
                    r    = int'($urandom_range(0, 15));
                    if (r == 0)      a_r = 32'h1000 + 32'($urandom_range(0, 255));
                    else if (r == 1) a_r = 32'hFFFF_FFFC;
                    else             a_r = 32'h100 + 32'($urandom_range(0, 63));
                    d_r = $urandom;
                    model(we_r, sz_r, a_r, d_r, erd, eerr);
                    drive(we_r, sz_r, a_r, d_r, erd, eerr);
                    have = 1'b1;
                end
            end
            cycle(f);
            if (f) begin
                have = 1'b0;
                n++;
            end
            cyc++;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        chk32("rand_issued", 32'(n), 32'd200);
        chk32("rand_drained", 32'(expq.size()), 32'd0);

        // Reset with three requests in flight.
        resp_ready = 1'b0;
        send(1'b0, 2'd2, 32'h10, 32'd0, 32'hABADBEEF, 1'b0);
        send(1'b0, 2'd2, 32'h20, 32'd0, 32'h12345678, 1'b0);
        send(1'b0, 2'd0, 32'h13, 32'd0, 32'h000000AB, 1'b0);
        cycle(f);
        chk1("t6_inflight_valid", resp_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk1("t6_rst_resp_valid", resp_valid, 1'b0);
        chk1("t6_rst_req_ready", req_ready, 1'b0);
        expq.delete();
        outst = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        resp_ready = 1'b1;
        repeat (8) begin
            chk1("t6_no_stale", resp_valid, 1'b0);
            cycle(f);
        end
        send(1'b0, 2'd2, 32'h10, 32'd0, 32'hABADBEEF, 1'b0);
        send(1'b0, 2'd2, 32'h20, 32'd0, 32'h12345678, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
